updown_count_sequencer: RTL and testbench

Command-driven controller that sequences an n-bit up/down counter through programmed passes: up, down, or bounce (triangle) between a start and an end value, repeated a programmed number of times.
Sits between a register/command master and the counting datapath. Accepts one command at a time via valid/ready and reports completion with a done pulse.
Supports pause, abort and illegal-command rejection.

---
 rtl/updown_count_sequencer_pkg.sv | 25 ++
 rtl/updown_counter_core.sv | 41 ++++
 rtl/updown_count_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_updown_count_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/updown_count_sequencer_pkg.sv
// Shared types and constants for the up/down count sequencer.
package updown_count_sequencer_pkg;

  // Controller states. IDLE is the only state that accepts a command.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Command mode encodings.
  localparam logic [1:0] MODE_UP      = 2'b00;
  localparam logic [1:0] MODE_DOWN    = 2'b01;
  localparam logic [1:0] MODE_BOUNCE  = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  // A command is rejected for the reserved mode, or for a bounce whose start
  // lies above its end (the triangle would have no valid shape).
  function automatic logic cmd_is_illegal(input logic [1:0] mode,
                                          input logic       start_gt_end);
    return (mode == MODE_ILLEGAL) || ((mode == MODE_BOUNCE) && start_gt_end);
  endfunction

endpackage

// File: rtl/updown_counter_core.sv
// N-bit up/down counter: synchronous load has priority over enable;
// dir=0 increments, dir=1 decrements, both wrapping modulo 2^N.
module updown_counter_core #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         en,
  input  logic         dir,
  output logic [N-1:0] q
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] q_d;
  logic [N-1:0] q_q;

  // Next count: load, else step in the requested direction, else hold.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (en) begin
      q_d = dir ? (q_q - ONE) : (q_q + ONE);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/updown_count_sequencer.sv
// Command-driven sequencer that runs an up/down counter through repeated
// up, down or bounce (triangle) passes between a captured start and end.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE, so the command
// fields are sampled exactly once per command and ignored in all other states.
module updown_count_sequencer
  import updown_count_sequencer_pkg::*;
#(
  parameter int N = 4,
  parameter int R = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [N-1:0] cmd_start,
  input  logic [N-1:0] cmd_end,
  input  logic [1:0]   cmd_mode,
  input  logic [R-1:0] cmd_reps,
  input  logic         pause,
  input  logic         abort,
  output logic [N-1:0] q,
  output logic         dir,
  output logic         busy,
  output logic         done,
  output logic         err,
  output state_e       dbg_state
);

  localparam logic [N-1:0] ONE_N = N'(1);
  localparam logic [R-1:0] ONE_R = R'(1);

  state_e       state_q, state_d;
  logic [R-1:0] reps_q, reps_d;
  logic         dir_q, dir_d;
  logic [N-1:0] start_q, start_d;
  logic [N-1:0] end_q, end_d;
  logic [1:0]   mode_q, mode_d;
  logic         err_q, err_d;

  // Counter core controls.
  logic         ld;
  logic [N-1:0] ld_val;
  logic         cnt_en;
  logic         cnt_dir;
  logic         pass_end;
  logic         at_end;
  logic         at_start;

  assign at_end   = (q == end_q);
  assign at_start = (q == start_q);

  // Next-state, captured command and counter control decode.
  always_comb begin
    state_d  = state_q;
    reps_d   = reps_q;
    dir_d    = dir_q;
    start_d  = start_q;
    end_d    = end_q;
    mode_d   = mode_q;
    err_d    = err_q;
    ld       = 1'b0;
    ld_val   = start_q;
    cnt_en   = 1'b0;
    cnt_dir  = dir_q;
    pass_end = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          start_d = cmd_start;
          end_d   = cmd_end;
          mode_d  = cmd_mode;
          if (cmd_is_illegal(cmd_mode, cmd_start > cmd_end)) begin
            // Rejected: q and dir stay as they were.
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            reps_d  = cmd_reps;
            dir_d   = (cmd_mode == MODE_DOWN);
            ld      = 1'b1;
            ld_val  = cmd_start;
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (pause) begin
          state_d = ST_HOLD;
        end else begin
          if (mode_q == MODE_BOUNCE) begin
            if (!dir_q) begin
              if (!at_end) begin
                cnt_en  = 1'b1;
                cnt_dir = 1'b0;
              end else if (start_q == end_q) begin
                pass_end = 1'b1;
              end else begin
                // Turn around at the top: step down in the same cycle.
                dir_d   = 1'b1;
                cnt_en  = 1'b1;
                cnt_dir = 1'b1;
              end
            end else begin
              if (!at_start) begin
                cnt_en  = 1'b1;
                cnt_dir = 1'b1;
              end else begin
                pass_end = 1'b1;
              end
            end
          end else begin
            if (at_end) begin
              pass_end = 1'b1;
            end else begin
              cnt_en  = 1'b1;
              cnt_dir = dir_q;
            end
          end

          if (pass_end) begin
            if (reps_q == '0) begin
              state_d = ST_DONE;
            end else begin
              reps_d = reps_q - ONE_R;
              ld     = 1'b1;
              // Bounce restarts at start+1 so the triangle does not repeat
              // the bottom value twice in a row.
              if ((mode_q == MODE_BOUNCE) && (start_q != end_q)) begin
                ld_val = start_q + ONE_N;
                dir_d  = 1'b0;
              end else begin
                ld_val = start_q;
              end
            end
          end
        end
      end

      ST_HOLD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      reps_q  <= '0;
      dir_q   <= 1'b0;
      start_q <= '0;
      end_q   <= '0;
      mode_q  <= MODE_UP;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      reps_q  <= reps_d;
      dir_q   <= dir_d;
      start_q <= start_d;
      end_q   <= end_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  updown_counter_core #(.N(N)) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (ld),
    .d    (ld_val),
    .en   (cnt_en),
    .dir  (cnt_dir),
    .q    (q)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_DONE) && err_q;
  assign dir       = dir_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_updown_count_sequencer.sv
// Directed bench for updown_count_sequencer with hand-computed sequences.
module tb_updown_count_sequencer;
  import updown_count_sequencer_pkg::*;

  localparam int N = 4;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [N-1:0] cmd_start = '0;
  logic [N-1:0] cmd_end = '0;
  logic [1:0]   cmd_mode = 2'b00;
  logic [R-1:0] cmd_reps = '0;
  logic         pause = 1'b0;
  logic         abort = 1'b0;
  logic [N-1:0] q;
  logic         dir;
  logic         busy;
  logic         done;
  logic         err;
  state_e       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {dir, q} per RUN cycle.
  logic [N:0] exp_q[$];

  updown_count_sequencer #(.N(N), .R(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_start (cmd_start),
    .cmd_end   (cmd_end),
    .cmd_mode  (cmd_mode),
    .cmd_reps  (cmd_reps),
    .pause     (pause),
    .abort     (abort),
    .q         (q),
    .dir       (dir),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; outputs are then sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [N-1:0] s, input logic [N-1:0] e,
                          input logic [1:0] m, input logic [R-1:0] r);
    cmd_start = s;
    cmd_end   = e;
    cmd_mode  = m;
    cmd_reps  = r;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Consume the expected RUN sequence, one cycle per entry.
  task automatic expect_run();
    while (exp_q.size() > 0) begin
      logic [N:0] e;
      e = exp_q.pop_front();
      check_val("run_q",     32'(q),         32'(e[N-1:0]));
      check_val("run_dir",   32'(dir),       32'(e[N]));
      check_val("run_busy",  32'(busy),      32'd1);
      check_val("run_ready", 32'(cmd_ready), 32'd0);
      check_val("run_done",  32'(done),      32'd0);
      tick();
    end
  endtask

  // One-cycle DONE pulse followed by a return to IDLE.
  task automatic expect_done(input logic [N-1:0] q_exp, input logic err_exp);
    check_val("done_pulse", 32'(done),      32'd1);
    check_val("done_err",   32'(err),       32'(err_exp));
    check_val("done_q",     32'(q),         32'(q_exp));
    check_val("done_busy",  32'(busy),      32'd0);
    check_val("done_ready", 32'(cmd_ready), 32'd0);
    tick();
    check_val("idle_done",  32'(done),      32'd0);
    check_val("idle_err",   32'(err),       32'd0);
    check_val("idle_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    // Reset values, observed while rst is still asserted.
    #2;
    check_val("rst_q",     32'(q),         32'd0);
    check_val("rst_dir",   32'(dir),       32'd0);
    check_val("rst_busy",  32'(busy),      32'd0);
    check_val("rst_done",  32'(done),      32'd0);
    check_val("rst_err",   32'(err),       32'd0);
    check_val("rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Up 2..5, two passes.
    send_cmd(4'd2, 4'd5, MODE_UP, 4'd1);
    for (int p = 0; p < 2; p++)
      for (int v = 2; v <= 5; v++) exp_q.push_back({1'b0, 4'(v)});
    expect_run();
    expect_done(4'd5, 1'b0);

    // Down 1..14 through the wrap.
    send_cmd(4'd1, 4'd14, MODE_DOWN, 4'd0);
    exp_q.push_back({1'b1, 4'd1});
    exp_q.push_back({1'b1, 4'd0});
    exp_q.push_back({1'b1, 4'd15});
    exp_q.push_back({1'b1, 4'd14});
    expect_run();
    expect_done(4'd14, 1'b0);

    // Bounce 3..5, two passes forming a continuous triangle.
    send_cmd(4'd3, 4'd5, MODE_BOUNCE, 4'd1);
    exp_q.push_back({1'b0, 4'd3});
    exp_q.push_back({1'b0, 4'd4});
    exp_q.push_back({1'b0, 4'd5});
    exp_q.push_back({1'b1, 4'd4});
    exp_q.push_back({1'b1, 4'd3});
    exp_q.push_back({1'b0, 4'd4});
    exp_q.push_back({1'b0, 4'd5});
    exp_q.push_back({1'b1, 4'd4});
    exp_q.push_back({1'b1, 4'd3});
    expect_run();
    expect_done(4'd3, 1'b0);

    // Up 14..1 through the wrap.
    send_cmd(4'd14, 4'd1, MODE_UP, 4'd0);
    exp_q.push_back({1'b0, 4'd14});
    exp_q.push_back({1'b0, 4'd15});
    exp_q.push_back({1'b0, 4'd0});
    exp_q.push_back({1'b0, 4'd1});
    expect_run();
    expect_done(4'd1, 1'b0);

    // Up 0..9, pause at 4 for three cycles, abort from HOLD.
    send_cmd(4'd0, 4'd9, MODE_UP, 4'd0);
    for (int v = 0; v <= 3; v++) exp_q.push_back({1'b0, 4'(v)});
    expect_run();
    check_val("pause_pre_q", 32'(q), 32'd4);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("hold_q",     32'(q),         32'd4);
      check_val("hold_state", 32'(dbg_state), 32'(ST_HOLD));
      check_val("hold_busy",  32'(busy),      32'd1);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    pause = 1'b0;
    check_val("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    check_val("abort_q",     32'(q),         32'd4);
    check_val("abort_ready", 32'(cmd_ready), 32'd1);
    check_val("abort_done",  32'(done),      32'd0);
    tick();
    check_val("abort_done2", 32'(done), 32'd0);
    check_val("abort_q2",    32'(q),    32'd4);

    // Illegal mode, then bounce with start above end.
    send_cmd(4'd1, 4'd2, MODE_ILLEGAL, 4'd3);
    check_val("ill_dir", 32'(dir), 32'd0);
    expect_done(4'd4, 1'b1);
    send_cmd(4'd6, 4'd2, MODE_BOUNCE, 4'd0);
    expect_done(4'd4, 1'b1);

    // Up 1..3 with a one-cycle pause: no step on the resume cycle.
    send_cmd(4'd1, 4'd3, MODE_UP, 4'd0);
    exp_q.push_back({1'b0, 4'd1});
    expect_run();
    check_val("pr_q2", 32'(q), 32'd2);
    pause = 1'b1;
    tick();
    pause = 1'b0;
    check_val("pr_hold_q",  32'(q),         32'd2);
    check_val("pr_hold_st", 32'(dbg_state), 32'(ST_HOLD));
    tick();
    check_val("pr_resume_q",  32'(q),         32'd2);
    check_val("pr_resume_st", 32'(dbg_state), 32'(ST_RUN));
    tick();
    check_val("pr_q3", 32'(q), 32'd3);
    tick();
    expect_done(4'd3, 1'b0);

    // Asynchronous reset mid-run at q=7.
    send_cmd(4'd5, 4'd12, MODE_UP, 4'd0);
    exp_q.push_back({1'b0, 4'd5});
    exp_q.push_back({1'b0, 4'd6});
    expect_run();
    check_val("arst_pre_q", 32'(q), 32'd7);
    rst = 1'b1;
    #1;
    check_val("arst_q",     32'(q),         32'd0);
    check_val("arst_busy",  32'(busy),      32'd0);
    check_val("arst_ready", 32'(cmd_ready), 32'd1);
    check_val("arst_done",  32'(done),      32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Zero-length pass accepted on the first edge after reset release.
    send_cmd(4'd9, 4'd9, MODE_UP, 4'd0);
    exp_q.push_back({1'b0, 4'd9});
    expect_run();
    expect_done(4'd9, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
